// File: rtl/wb_sequencer.sv
// wb_sequencer: four-state control sequencer for ALU/MOVE/LI/LOAD/STORE writeback.
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   instr_valid/instr_ready    instruction handshake; op_class and dest_reg are captured on transfer
//   mem_req, mem_we, mem_ack   data-memory request/write qualifier; one-cycle completion pulse
//   is_move/is_mem_access/is_li writeback source selects (all low = ALU result)
//   reg_write, wr_reg          register-file write enable and index
//   mem_err                    sticky memory-timeout flag
//   instr_count                retired-instruction counter (wraps)
module wb_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] op_class,
    input  logic [2:0] dest_reg,
    output logic       mem_req,
    output logic       mem_we,
    input  logic       mem_ack,
    output logic       is_move,
    output logic       is_mem_access,
    output logic       is_li,
    output logic       reg_write,
    output logic [2:0] wr_reg,
    output logic       mem_err,
    output logic [7:0] instr_count
);
    localparam logic [2:0] OP_MOVE  = 3'd1;
    localparam logic [2:0] OP_LI    = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_STORE = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT, WB} state_t;

    state_t     state, state_nx;
    logic [2:0] op, dest;
    logic [7:0] tcnt;
    logic       retire, timeout;

    // tcnt counts completed ack-less MEM_WAIT cycles; the cycle that would make it
    // reach MEM_TIMEOUT aborts instead, so MEM_WAIT lasts at most MEM_TIMEOUT cycles.
    assign timeout = state == MEM_WAIT && !mem_ack && tcnt == 8'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op          <= '0;
            dest        <= '0;
            tcnt        <= '0;
            mem_err     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && instr_valid) begin
                op   <= op_class;
                dest <= dest_reg;
            end
            // Held at zero outside MEM_WAIT, which also clears it on entry.
            tcnt <= (state == MEM_WAIT && !mem_ack) ? tcnt + 8'd1 : 8'd0;
            if (timeout)
                mem_err <= 1'b1;
            if (retire)
                instr_count <= instr_count + 8'd1;
        end
    end

    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        unique case (state)
            IDLE: state_nx = instr_valid ? EXEC : IDLE;
            EXEC: begin
                state_nx = op <= OP_LI ? WB : (op == OP_LOAD || op == OP_STORE) ? MEM_WAIT : IDLE;
                retire   = op > OP_STORE;
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_nx = op == OP_LOAD ? WB : IDLE;
                    retire   = op == OP_STORE;
                end else if (timeout) begin
                    state_nx = IDLE;
                end
            end
            WB: begin
                state_nx = IDLE;
                retire   = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign instr_ready   = state == IDLE;
    assign mem_req       = state == MEM_WAIT;
    assign mem_we        = state == MEM_WAIT && op == OP_STORE;
    assign reg_write     = state == WB;
    assign wr_reg        = state == WB ? dest : 3'd0;
    assign is_move       = state == WB && op == OP_MOVE;
    assign is_mem_access = state == WB && op == OP_LOAD;
    assign is_li         = state == WB && op == OP_LI;
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: vector table, random instructions vs transaction model, reset and wrap sequences.
module tb_wb_sequencer;
    localparam int T = 15;

    logic       clk, rst_n, instr_valid, instr_ready, mem_req, mem_we, mem_ack;
    logic       is_move, is_mem_access, is_li, reg_write, mem_err;
    logic [2:0] op_class, dest_reg, wr_reg;
    logic [7:0] instr_count;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] m_cnt = 8'd0;
    bit         m_err = 1'b0;

    wb_sequencer #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op_class(op_class), .dest_reg(dest_reg), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ack(mem_ack), .is_move(is_move), .is_mem_access(is_mem_access), .is_li(is_li),
        .reg_write(reg_write), .wr_reg(wr_reg), .mem_err(mem_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [2:0] dest;
        int         ack;
        logic [2:0] sel;
        bit         wb;
        int         memc;
        bit         ret;
        bit         err;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [18:0] ev(bit r, bit q, bit w, bit rw, logic [2:0] wr,
                                       logic [2:0] sel, bit e, logic [7:0] c);
        return {r, q, w, rw, wr, sel, e, c};
    endfunction

    task automatic chk(input string name, input logic [18:0] exp);
        logic [18:0] got;
        got = {instr_ready, mem_req, mem_we, reg_write, wr_reg, is_move, is_mem_access, is_li,
               mem_err, instr_count};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b expected %b (rdy req we rw wr[3] mv mem li err cnt[8])",
                     name, $time, got, exp);
        end
    endtask

    // Transaction-level expectations derived from the instruction class and ack timing.
    task automatic model(input logic [2:0] op, input int ack, output logic [2:0] sel, output bit wb,
                         output int memc, output bit ret, output bit err);
        bit acked;
        acked = ack >= 1 && ack <= T;
        sel = op == 3'd1 ? 3'b100 : op == 3'd2 ? 3'b001 : (op == 3'd3 && acked) ? 3'b010 : 3'b000;
        memc = (op == 3'd3 || op == 3'd4) ? (acked ? ack : T) : 0;
        wb = op <= 3'd2 || (op == 3'd3 && acked);
        err = (op == 3'd3 || op == 3'd4) && !acked;
        ret = !err;
    endtask

    // Entered just after a negedge with the DUT idle; returns at the negedge of the next idle cycle.
    task automatic do_instr(input logic [2:0] op, input logic [2:0] dest, input int ack,
                            input logic [2:0] sel, input bit wb, input int memc, input bit ret,
                            input bit err);
        chk("idle", ev(1, 0, 0, 0, 3'd0, 3'd0, m_err, m_cnt));
        instr_valid = 1'b1;
        op_class = op;
        dest_reg = dest;
        mem_ack = 1'($urandom);
        @(negedge clk);
        instr_valid = 1'b0;
        op_class = 3'($urandom);
        dest_reg = 3'($urandom);
        chk("exec", ev(0, 0, 0, 0, 3'd0, 3'd0, m_err, m_cnt));
        mem_ack = 1'($urandom);
        for (int k = 1; k <= memc; k++) begin
            @(negedge clk);
            chk("mem_wait", ev(0, 1, op == 3'd4, 0, 3'd0, 3'd0, m_err, m_cnt));
            mem_ack = k == ack;
        end
        if (wb) begin
            @(negedge clk);
            mem_ack = 1'($urandom);
            chk("wb", ev(0, 0, 0, 1, dest, sel, m_err, m_cnt));
        end
        @(negedge clk);
        mem_ack = 1'b0;
        m_cnt += 8'(ret);
        m_err |= err;
    endtask

    initial begin
        logic [2:0] op, dest, sel;
        bit         wb, ret, err;
        int         ack, memc;
        tbl[0]  = '{3'd1, 3'd5, 0,  3'b100, 1, 0, 1, 0};
        tbl[1]  = '{3'd3, 3'd3, 4,  3'b010, 1, 4, 1, 0};
        tbl[2]  = '{3'd4, 3'd2, T,  3'b000, 0, T, 1, 0};
        tbl[3]  = '{3'd0, 3'd1, 0,  3'b000, 1, 0, 1, 0};
        tbl[4]  = '{3'd2, 3'd6, 0,  3'b001, 1, 0, 1, 0};
        tbl[5]  = '{3'd5, 3'd4, 0,  3'b000, 0, 0, 1, 0};
        tbl[6]  = '{3'd3, 3'd0, 1,  3'b010, 1, 1, 1, 0};
        tbl[7]  = '{3'd4, 3'd7, 2,  3'b000, 0, 2, 1, 0};
        tbl[8]  = '{3'd4, 3'd1, 0,  3'b000, 0, T, 0, 1};
        tbl[9]  = '{3'd3, 3'd4, 0,  3'b000, 0, T, 0, 1};
        tbl[10] = '{3'd7, 3'd3, 0,  3'b000, 0, 0, 1, 0};
        tbl[11] = '{3'd6, 3'd2, 0,  3'b000, 0, 0, 1, 0};

        clk = 1'b0;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        op_class = 3'd0;
        dest_reg = 3'd0;
        mem_ack = 1'b0;
        #12;
        chk("reset", ev(1, 0, 0, 0, 3'd0, 3'd0, 0, 8'd0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            do_instr(tbl[i].op, tbl[i].dest, tbl[i].ack, tbl[i].sel, tbl[i].wb, tbl[i].memc,
                     tbl[i].ret, tbl[i].err);

        mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_hold", ev(1, 0, 0, 0, 3'd0, 3'd0, m_err, m_cnt));
        end
        mem_ack = 1'b0;

        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom);
            dest = 3'($urandom);
            ack = int'($urandom_range(0, T + 3));
            model(op, ack, sel, wb, memc, ret, err);
            do_instr(op, dest, ack, sel, wb, memc, ret, err);
        end

        instr_valid = 1'b1;
        op_class = 3'd2;
        dest_reg = 3'd7;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("li_wb", ev(0, 0, 0, 1, 3'd7, 3'b001, m_err, m_cnt));
        #2 rst_n = 1'b0;
        #1 chk("reset_in_wb", ev(1, 0, 0, 0, 3'd0, 3'd0, 0, 8'd0));
        m_cnt = 8'd0;
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 256; n++)
            do_instr(3'd5, 3'($urandom), 0, 3'b000, 0, 0, 1, 0);
        chk("nop_wrap", ev(1, 0, 0, 0, 3'd0, 3'd0, 0, 8'd0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
